// File: rtl/board_commit.sv
// board_commit: writer side of the 10x20 playfield board read by the DVI renderer.
// Locks a landed tetromino into the board, removes full rows bottom-up and
// reports how many rows were cleared.
// Optional build macro VBLANK_COMMIT_EN: o_board becomes a shadow copy that is
// refreshed only during vertical blanking while idle. Without it, o_board is
// the working board, and the intermediate write and shift steps are visible.
module board_commit (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_lock_valid,
    output logic          o_lock_ready,
    input  logic [3:0]    i_blk_id,
    input  logic [4:0]    i_cell_x0,
    input  logic [4:0]    i_cell_x1,
    input  logic [4:0]    i_cell_x2,
    input  logic [4:0]    i_cell_x3,
    input  logic [4:0]    i_cell_y0,
    input  logic [4:0]    i_cell_y1,
    input  logic [4:0]    i_cell_y2,
    input  logic [4:0]    i_cell_y3,
    input  logic          i_clear,
    input  logic          i_vblank,
    output logic [1023:0] o_board,
    output logic          o_done,
    output logic [2:0]    o_lines,
    output logic          o_err
);
    // state | meaning
    // IDLE  | ready for a lock request or a board clear
    // WRITE | writing piece cell k (k = 0..3), one per cycle
    // SCAN  | checking row r for fullness, bottom (19) to top (0)
    // SHIFT | moving row s-1 down into row s, ending with row 0 zeroed
    // DONE  | one-cycle completion pulse, o_lines valid

    localparam int BOARD_W    = 10;
    localparam int BOARD_H    = 20;
    localparam int CELL_W     = 4;
    localparam int ROW_BITS   = BOARD_W * CELL_W;
    localparam int BOARD_BITS = ROW_BITS * BOARD_H;

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_SCAN, S_SHIFT, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [BOARD_BITS-1:0] board_q;
    logic [3:0]            id_q;
    logic [4:0]            x_q [4];
    logic [4:0]            y_q [4];
    logic [1:0]            k_q;
    logic [4:0]            r_q;
    logic [4:0]            s_q;
    logic [2:0]            cnt_q;
    logic [2:0]            lines_q;
    logic                  err_q;

    logic [4:0]            cur_x, cur_y;
    logic                  id_ok, cell_in, cell_busy, row_full;
    logic [9:0]            cell_base, r_base, s_base, sm1_base;
    logic [ROW_BITS-1:0]   scan_row;

    // Address decode for the cell being written and the row being scanned/shifted.
    always_comb begin
        cur_x     = x_q[k_q];
        cur_y     = y_q[k_q];
        id_ok     = (id_q != 4'd0) && !id_q[3];
        cell_in   = (cur_x < 5'd10) && (cur_y < 5'd20);
        cell_base = ({5'd0, cur_y} * 10'd10 + {5'd0, cur_x}) << 2;
        cell_busy = cell_in && (board_q[cell_base +: CELL_W] != '0);
        r_base    = {5'd0, r_q} * 10'd40;
        s_base    = {5'd0, s_q} * 10'd40;
        sm1_base  = s_base - 10'd40;
        scan_row  = board_q[r_base +: ROW_BITS];
        row_full  = 1'b1;
        for (int c = 0; c < BOARD_W; c++) begin
            if (scan_row[c*CELL_W +: CELL_W] == '0) row_full = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d      = state_q;
        o_lock_ready = 1'b0;
        o_done       = 1'b0;
        case (state_q)
            S_IDLE: begin
                o_lock_ready = 1'b1;
                if (!i_clear && i_lock_valid) state_d = S_WRITE;
            end
            S_WRITE: if (k_q == 2'd3) state_d = S_SCAN;
            S_SCAN: begin
                if (row_full)          state_d = S_SHIFT;
                else if (r_q == 5'd0)  state_d = S_DONE;
            end
            S_SHIFT: if (s_q == 5'd0) state_d = S_SCAN;
            S_DONE: begin
                o_done  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Board datapath: request latch, cell writes, row scan/shift, counters and error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            board_q <= '0;
            id_q    <= '0;
            for (int i = 0; i < 4; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
            end
            k_q     <= '0;
            r_q     <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            lines_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_clear) begin
                        board_q <= '0;
                        err_q   <= 1'b0;
                    end else if (i_lock_valid) begin
                        id_q   <= i_blk_id;
                        x_q[0] <= i_cell_x0;
                        x_q[1] <= i_cell_x1;
                        x_q[2] <= i_cell_x2;
                        x_q[3] <= i_cell_x3;
                        y_q[0] <= i_cell_y0;
                        y_q[1] <= i_cell_y1;
                        y_q[2] <= i_cell_y2;
                        y_q[3] <= i_cell_y3;
                        k_q    <= '0;
                        r_q    <= 5'd19;
                        cnt_q  <= '0;
                    end
                end
                S_WRITE: begin
                    if (!id_ok || !cell_in) begin
                        err_q <= 1'b1;
                    end else begin
                        if (cell_busy) err_q <= 1'b1;
                        board_q[cell_base +: CELL_W] <= id_q;
                    end
                    k_q <= k_q + 2'd1;
                end
                S_SCAN: begin
                    if (row_full) begin
                        if (cnt_q != 3'd7) cnt_q <= cnt_q + 3'd1;
                        s_q <= r_q;
                    end else if (r_q == 5'd0) begin
                        lines_q <= cnt_q;
                    end else begin
                        r_q <= r_q - 5'd1;
                    end
                end
                S_SHIFT: begin
                    if (s_q != 5'd0) begin
                        board_q[s_base +: ROW_BITS] <= board_q[sm1_base +: ROW_BITS];
                        s_q <= s_q - 5'd1;
                    end else begin
                        board_q[ROW_BITS-1:0] <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_lines = lines_q;
    assign o_err   = err_q;

`ifdef VBLANK_COMMIT_EN
    logic [BOARD_BITS-1:0] shadow_q;

    // Publish the working board only while idle in blanking so no partial update is seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                            shadow_q <= '0;
        else if (i_vblank && state_q == S_IDLE) shadow_q <= board_q;
    end

    assign o_board = {{(1024-BOARD_BITS){1'b0}}, shadow_q};
`else
    logic unused_vblank;
    assign unused_vblank = i_vblank;
    assign o_board = {{(1024-BOARD_BITS){1'b0}}, board_q};
`endif

endmodule

// File: doc/board_commit.md
Name: board_commit

Overview:
- Writer side of the playfield board that the DVI renderer reads.
- Locks a landed tetromino into the 10x20 board, detects and removes full rows, and reports the number of rows cleared.
- Sits between game control and the renderer; drives the renderer's 1024-bit board bus.
- Board layout: cell (x,y) occupies bits [(y*10+x)*4 +: 4]; value 0 means empty, 1..7 is the piece colour id.

Parameters:
- BOARD_W, 10, columns; fixed by the layout, not for override.
- BOARD_H, 20, rows; fixed by the layout, not for override.
- CELL_W, 4, bits per cell.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- i_lock_valid  in  1  lock request
- o_lock_ready  out  1  high when idle and able to accept a request
- i_blk_id  in  4  colour id to store, valid 1..7
- i_cell_x0..i_cell_x3  in  5 each  absolute column of piece cells 0..3
- i_cell_y0..i_cell_y3  in  5 each  absolute row of piece cells 0..3
- i_clear  in  1  clear the whole board; honoured only in IDLE
- i_vblank  in  1  vertical blanking indicator from the video timing
- o_board  out  1024  board image sent to the renderer
- o_done  out  1  one-cycle pulse when a lock operation completes
- o_lines  out  3  rows cleared by the last lock; held until the next o_done
- o_err  out  1  sticky flag, cleared only by i_clear: out-of-range cell, overlap, or i_blk_id outside 1..7

Behaviour:
- Reset: working board all zero; o_board 0; o_lock_ready 1; o_done 0; o_lines 0; o_err 0; FSM in IDLE.
- FSM states: IDLE, WRITE, SCAN, SHIFT, DONE.
- IDLE:
  - o_lock_ready=1.
  - i_clear has priority over i_lock_valid: it zeroes the board and o_err in one cycle and does not accept a lock that cycle.
  - i_lock_valid && o_lock_ready at edge T latches the id and all 8 coordinates, then goes to WRITE.
- WRITE: 4 cycles (T+1..T+4), cell k written in cycle k.
  - A cell with x>=10 or y>=20 is skipped and sets o_err.
  - A cell that is already non-zero is overwritten and sets o_err.
  - If the id is 0 or >=8, no cells are written, o_err is set, and the FSM still proceeds through SCAN.
- SCAN: row pointer r starts at 19 and checks one row per cycle.
  - Row full (all 10 cells non-zero): line counter +1 (saturates at 7), go to SHIFT with s=r.
  - Otherwise: if r==0 go to DONE, else r-1.
- SHIFT: one row per cycle.
  - s>0: row s <= row s-1, then s-1.
  - s==0: row 0 <= 0, return to SCAN with r unchanged, so the shifted-in row is rescanned.
  - Cost per cleared row r is r+1 cycles plus 1 rescan cycle.
- DONE: one cycle.
  - o_done=1 and o_lines=counter.
  - Next state is IDLE.
- Latency with no full rows: accept at T, o_done high in cycle T+25, o_lock_ready high again at T+26.
- o_lock_ready is 0 in every state except IDLE. i_lock_valid and i_clear are ignored when not in IDLE.
- o_board bits [1023:800] are always 0.
- Reset asserted mid-operation aborts immediately to the reset state; the board becomes all zero.

Optional Feature:
- VBLANK_COMMIT_EN defined:
  - o_board is a separate shadow register.
  - It copies the working board on any cycle where i_vblank=1 and the FSM is in IDLE, so the renderer never sees partial updates.
  - o_board lags until the next qualifying vblank cycle.
- VBLANK_COMMIT_EN undefined:
  - o_board is the working board directly and shows intermediate WRITE/SHIFT states.
  - i_vblank is ignored.

Test Plan:
- Reset, then lock id 1 at cells (0,19),(1,19),(2,19),(3,19) on an empty board -> those 4 cells = 1, o_done at T+25, o_lines=0, o_err=0.
- Lock id 2 at (4..7,19), then id 3 at (8,19),(9,19),(8,18),(9,18) -> second lock reports o_lines=1. Afterwards row 19 has cells 8,9 = 3 and everything else is empty.
- Fill rows 18 and 19 except column 9; lock a vertical I (id 4) at (9,16..19) -> o_lines=2; (9,18) and (9,19) = 4; rows 0..17 empty.
- Lock with a cell at (10,5) and a cell on an occupied square -> out-of-range cell not written, overlap cell overwritten, o_err=1. Pulse i_clear in IDLE -> board 0, o_err=0.
- Assert i_lock_valid during SCAN -> not accepted, o_lock_ready=0. Drop rst_n during SHIFT -> all outputs return to reset values asynchronously.
- With VBLANK_COMMIT_EN and i_vblank=0, complete a lock -> o_board unchanged. Raise i_vblank in IDLE -> o_board equals the working board on the next edge.
